// File: rtl/check_result_pkg.sv
// Shared defaults for the round-checking block: datapath width, winning score
// and the round number that ends the game.
package check_result_pkg;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_WIN_VALUE  = 4;
    localparam int unsigned DEF_LAST_ROUND = 7;

endpackage

// File: rtl/check_result_comparator.sv
// Unsigned magnitude comparator: flags A<B, A==B and A>B.
module Comparator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             AltB,
    output logic             AeqB,
    output logic             AgtB
);

    always_comb begin
        AltB = (A <  B);
        AeqB = (A == B);
        AgtB = (A >  B);
    end

endmodule

// File: rtl/check_result_counter.sv
// Up/down counter with async reset, sync clear, parallel load and count enable,
// in that priority order.
module Counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (clear) begin
            Q <= '0;
        end else if (load) begin
            Q <= D;
        end else if (en) begin
            // Wraps modulo 2^WIDTH in both directions.
            Q <= up ? Q + WIDTH'(1) : Q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/check_result.sv
// Game-state checker: counts rounds and flags a win or the end of the game.
module check_result
    import check_result_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned WIN_VALUE  = DEF_WIN_VALUE,
    parameter int unsigned LAST_ROUND = DEF_LAST_ROUND
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             C_chk_clr,
    input  logic [WIDTH-1:0] Znarly,
    output logic [WIDTH-1:0] RoundNumber,
    output logic             GameWon,
    output logic             GameFinished
);

    logic       last_round;
    // Ordering/inequality outputs of both comparators are not needed here.
    logic [3:0] unused_cmp;

    Comparator #(.WIDTH(WIDTH)) u_win_cmp (
        .A    (Znarly),
        .B    (WIDTH'(WIN_VALUE)),
        .AltB (unused_cmp[0]),
        .AeqB (GameWon),
        .AgtB (unused_cmp[1])
    );

    Comparator #(.WIDTH(WIDTH)) u_round_cmp (
        .A    (RoundNumber),
        .B    (WIDTH'(LAST_ROUND)),
        .AltB (unused_cmp[2]),
        .AeqB (last_round),
        .AgtB (unused_cmp[3])
    );

    Counter #(.WIDTH(WIDTH)) u_round_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (C_chk_clr),
        .en      (~C_chk_clr),
        .up      (1'b1),
        .load    (1'b0),
        .D       ('0),
        .Q       (RoundNumber)
    );

    assign GameFinished = GameWon | last_round;

endmodule

// File: tb/tb_check_result.sv
// Randomized and directed self-checking bench for check_result against a
// round-count reference model.
module tb_check_result;

    logic       clock;
    logic       reset_n;
    logic       C_chk_clr;
    logic [3:0] Znarly;
    logic [3:0] RoundNumber;
    logic       GameWon;
    logic       GameFinished;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rn_model = 0;

    check_result #(.WIDTH(4), .WIN_VALUE(4), .LAST_ROUND(7)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .C_chk_clr    (C_chk_clr),
        .Znarly       (Znarly),
        .RoundNumber  (RoundNumber),
        .GameWon      (GameWon),
        .GameFinished (GameFinished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the game rules applied to the model round count.
    task automatic check_all(input string tag);
        int unsigned won;
        won = (int'(Znarly) == 4) ? 1 : 0;
        check({tag, ".round"}, RoundNumber, rn_model);
        check({tag, ".won"}, GameWon, won);
        check({tag, ".fin"}, GameFinished, (won == 1 || rn_model == 7) ? 1 : 0);
    endtask

    // One clock edge: advance the model, then sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge clock);
        if (!reset_n)       rn_model = 0;
        else if (C_chk_clr) rn_model = 0;
        else                rn_model = (rn_model + 1) % 16;
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        C_chk_clr = 1'b0;
        Znarly    = 4'd0;
        #3;
        check("rst_noclk.round", RoundNumber, 0);
        check("rst_noclk.won", GameWon, 0);
        check("rst_noclk.fin", GameFinished, 0);
        Znarly = 4'd4;
        #1;
        check("rst_win.won", GameWon, 1);
        check("rst_win.fin", GameFinished, 1);
        Znarly = 4'd0;
        step("in_reset");
        #2 reset_n = 1'b1;

        // Clear then count 1,2,3
        C_chk_clr = 1'b1;
        step("clr");
        C_chk_clr = 1'b0;
        for (int i = 0; i < 3; i++) step("count");

        // Win flags at round 2
        C_chk_clr = 1'b1;
        step("clr2");
        C_chk_clr = 1'b0;
        step("r1");
        step("r2");
        Znarly = 4'd4;
        #1;
        check("win_r2.won", GameWon, 1);
        check("win_r2.fin", GameFinished, 1);
        Znarly = 4'd3;
        #1;
        check("nowin_r2.won", GameWon, 0);
        check("nowin_r2.fin", GameFinished, 0);

        // Last round and wrap
        C_chk_clr = 1'b1;
        step("clr3");
        C_chk_clr = 1'b0;
        for (int i = 0; i < 7; i++) step("to_last");
        check("last.round", RoundNumber, 7);
        check("last.fin", GameFinished, 1);
        check("last.won", GameWon, 0);
        Znarly = 4'd9;
        #1;
        check("last_z9.fin", GameFinished, 1);
        Znarly = 4'd3;
        step("after_last");
        check("after_last.fin", GameFinished, 0);
        for (int i = 0; i < 8; i++) step("to_wrap");
        check("wrap.round", RoundNumber, 0);

        // Async reset mid-count at round 5
        C_chk_clr = 1'b1;
        step("clr4");
        C_chk_clr = 1'b0;
        for (int i = 0; i < 5; i++) step("to5");
        #2 reset_n = 1'b0;
        #1;
        rn_model = 0;
        check("async_rst.round", RoundNumber, 0);
        #1 reset_n = 1'b1;
        step("resume1");
        check("resume1.round", RoundNumber, 1);
        step("resume2");
        check("resume2.round", RoundNumber, 2);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            C_chk_clr = ($urandom_range(0, 5) == 0);
            Znarly    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) Znarly = 4'd4;
            #1;
            check_all("rand_comb");
            if ($urandom_range(0, 40) == 0) begin
                reset_n = 1'b0;
                #1;
                rn_model = 0;
                check_all("rand_rst");
                reset_n = 1'b1;
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/check_result.md
CHECK_RESULT -- requirements
Module: check_result

Interface
REQ-001 Parameter WIDTH, default 4, bit width of Znarly, RoundNumber and both sub-module datapaths.
REQ-002 Parameter WIN_VALUE, default 4, Znarly value that wins the game.
REQ-003 Parameter LAST_ROUND, default 7, RoundNumber value that ends the game.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 C_chk_clr  input  1  synchronous round-counter clear, active-high.
REQ-007 Znarly  input  WIDTH  score of the current guess (count of correct items).
REQ-008 RoundNumber  output  WIDTH  current round count, registered.
REQ-009 GameWon  output  1  combinational win flag.
REQ-010 GameFinished  output  1  combinational end-of-game flag.

Function
REQ-011 GameWon SHALL be 1 exactly when Znarly == WIN_VALUE, combinationally, with zero latency.
REQ-012 GameFinished SHALL be GameWon OR (RoundNumber == LAST_ROUND), combinationally.
REQ-013 On each rising clock edge with C_chk_clr=1, RoundNumber SHALL load 0.
REQ-014 On each rising clock edge with C_chk_clr=0, RoundNumber SHALL increment by 1.
REQ-015 Increment SHALL be modulo 2^WIDTH: 15 -> 0 at WIDTH=4; no saturation and no stop at LAST_ROUND.
REQ-016 C_chk_clr SHALL take priority over increment when both apply in the same cycle.
REQ-017 Changes on Znarly SHALL NOT affect RoundNumber.
REQ-018 GameFinished SHALL stay asserted while RoundNumber == LAST_ROUND, whatever the value of Znarly.
REQ-019 GameWon and GameFinished SHALL have no internal state; they follow their inputs within the same cycle.

Reset
REQ-020 reset_n=0 SHALL force RoundNumber to 0 immediately, independent of clock.
REQ-021 During reset, GameWon SHALL reflect Znarly per REQ-011, and GameFinished SHALL equal GameWon.
REQ-022 After reset_n is released, the first rising edge SHALL apply REQ-013/REQ-014 normally.
REQ-023 Asserting reset mid-count SHALL discard the count; counting resumes from 0.

Structure
REQ-024 A shared package SHALL hold the default WIDTH, WIN_VALUE and LAST_ROUND constants.
REQ-025 Sub-module Comparator #(WIDTH) SHALL provide:
  - inputs A, B; outputs AltB, AeqB, AgtB (unsigned);
  - two instances: Znarly vs WIN_VALUE, and RoundNumber vs LAST_ROUND.
REQ-026 Sub-module Counter #(WIDTH) SHALL provide:
  - ports clock, reset_n, clear, en, up, load, D, Q;
  - priority order: async reset > clear > load > count when en;
  - up=1 counts up, up=0 counts down.
REQ-027 check_result SHALL tie the Counter as follows:
  - en = ~C_chk_clr, up = 1, load = 0, D = 0;
  - clear = C_chk_clr, Q drives RoundNumber.
REQ-028 check_result SHALL contain no logic other than the two Comparators, the Counter and one OR gate.

Verification
REQ-029 Apply reset_n=0 with Znarly=0 -> RoundNumber=0, GameWon=0, GameFinished=0 without any clock edge.
REQ-030 Set C_chk_clr=1 for one edge, then 0 for 3 edges -> RoundNumber steps 0,1,2,3.
REQ-031 Set Znarly=4 with RoundNumber=2 -> GameWon=1 and GameFinished=1 in the same cycle; Znarly=3 -> both 0.
REQ-032 Clear, then count with Znarly=3:
  - at RoundNumber=7 -> GameFinished=1, GameWon=0;
  - next edge, RoundNumber=8 -> GameFinished=0.
REQ-033 Count past 15 -> RoundNumber wraps to 0.
REQ-034 Assert reset_n=0 at RoundNumber=5 between clock edges -> RoundNumber=0 immediately, then counts 1,2 after release.
